// File: rtl/apb_ratio_delayer.sv
// APB transfer stretcher: scales slave latency by a fixed-point ratio
// or adds a fixed cycle count, with a runtime combinational bypass.
module apb_ratio_delayer #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MODE      = 0,
   parameter int S         = 3,
   parameter int R_FX      = 80,
   parameter int FIXED_DLY = 16,
   parameter int CNT_W     = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_bypass,
   input  logic [ADDR_W-1:0]   in_paddr,
   input  logic                in_psel,
   input  logic                in_penable,
   input  logic [2:0]          in_pprot,
   input  logic                in_pwrite,
   input  logic [DATA_W-1:0]   in_pwdata,
   input  logic [DATA_W/8-1:0] in_pstrb,
   output logic                in_pready,
   output logic [DATA_W-1:0]   in_prdata,
   output logic                in_pslverr,
   output logic [ADDR_W-1:0]   out_paddr,
   output logic                out_psel,
   output logic                out_penable,
   output logic [2:0]          out_pprot,
   output logic                out_pwrite,
   output logic [DATA_W-1:0]   out_pwdata,
   output logic [DATA_W/8-1:0] out_pstrb,
   input  logic                out_pready,
   input  logic [DATA_W-1:0]   out_prdata,
   input  logic                out_pslverr,
   output logic                busy
);

   localparam logic [CNT_W-1:0] LP_MAX = '1;
   localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LP_RFX = CNT_W'(R_FX);
   localparam logic [CNT_W-1:0] LP_FIX = CNT_W'(FIXED_DLY);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DELAY,
      ST_RESP
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_k;
   logic [CNT_W-1:0]  r_dcnt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_pslverr;
   logic              r_byp;

   logic [CNT_W:0]    w_acc_sum;
   logic [CNT_W:0]    w_k_sum;
   logic [CNT_W-1:0]  w_acc_cur;
   logic [CNT_W-1:0]  w_k_cur;
   logic [CNT_W-1:0]  w_acc_sh;
   logic [CNT_W-1:0]  w_dly;
   logic              w_start;
   logic              w_pass;
   logic              w_hold;

   assign w_start = in_psel & in_penable & ~r_byp;
   assign w_pass  = (r_state == ST_IDLE) & r_byp;
   assign w_hold  = (r_state == ST_DELAY) | (r_state == ST_RESP);

   // Cycle count and accumulator including the current access cycle, plus the delay they imply
   always_comb begin
      w_acc_sum = {1'b0, r_acc} + {1'b0, LP_RFX};
      w_k_sum   = {1'b0, r_k} + {1'b0, LP_ONE};
      w_acc_cur = LP_RFX;
      w_k_cur   = LP_ONE;
      if (r_state == ST_ACCESS) begin
         w_acc_cur = w_acc_sum[CNT_W] ? LP_MAX : w_acc_sum[CNT_W-1:0];
         w_k_cur   = w_k_sum[CNT_W]   ? LP_MAX : w_k_sum[CNT_W-1:0];
      end
      w_acc_sh = w_acc_cur >> S;
      if (MODE == 1) begin
         w_dly = LP_FIX;
      end else if (w_acc_sh > w_k_cur) begin
         w_dly = w_acc_sh - w_k_cur;
      end else begin
         w_dly = '0;
      end
   end

   // Downstream request mirrors upstream; select/enable/prot are held off once the response is captured
   assign out_paddr   = in_paddr;
   assign out_pwrite  = in_pwrite;
   assign out_pwdata  = in_pwdata;
   assign out_pstrb   = in_pstrb;
   assign out_psel    = w_hold ? 1'b0 : in_psel;
   assign out_penable = w_hold ? 1'b0 : in_penable;
   assign out_pprot   = w_hold ? 3'b000 : in_pprot;

   // Upstream response is either the live slave (bypass) or the held capture
   assign in_pready  = w_pass ? out_pready  : (r_state == ST_RESP);
   assign in_prdata  = w_pass ? out_prdata  : r_rdata;
   assign in_pslverr = w_pass ? out_pslverr : r_pslverr;
   assign busy       = (r_state != ST_IDLE);

   // Transfer sequencer: count access cycles, capture response, hold for the computed delay
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_acc     <= '0;
         r_k       <= '0;
         r_dcnt    <= '0;
         r_rdata   <= '0;
         r_pslverr <= 1'b0;
         r_byp     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_byp <= cfg_bypass;
               if (w_start) begin
                  r_k   <= w_k_cur;
                  r_acc <= w_acc_cur;
                  if (out_pready) begin
                     r_rdata   <= out_prdata;
                     r_pslverr <= out_pslverr;
                     r_dcnt    <= w_dly;
                     r_state   <= (w_dly != '0) ? ST_DELAY : ST_RESP;
                  end else begin
                     r_state <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (!in_psel) begin
                  r_state <= ST_IDLE;
                  r_acc   <= '0;
                  r_k     <= '0;
               end else begin
                  r_k   <= w_k_cur;
                  r_acc <= w_acc_cur;
                  if (out_pready) begin
                     r_rdata   <= out_prdata;
                     r_pslverr <= out_pslverr;
                     r_dcnt    <= w_dly;
                     r_state   <= (w_dly != '0) ? ST_DELAY : ST_RESP;
                  end
               end
            end
            ST_DELAY: begin
               r_dcnt <= r_dcnt - LP_ONE;
               if (r_dcnt == LP_ONE) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_acc   <= '0;
               r_k     <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_ratio_delayer.sv
// Bench for apb_ratio_delayer: four parameterisations driven in parallel,
// table-driven transfers with a response scoreboard plus corner sequences.
module tb_apb_ratio_delayer;

   localparam int P_RFX  [4] = '{8, 80, 12, 80};
   localparam int P_MODE [4] = '{0, 0, 0, 1};

   logic clock;
   logic reset;
   logic cfg_bypass;
   logic [31:0] in_paddr;
   logic in_psel;
   logic in_penable;
   logic [2:0] in_pprot;
   logic in_pwrite;
   logic [31:0] in_pwdata;
   logic [3:0] in_pstrb;
   logic out_pready;
   logic [31:0] out_prdata;
   logic out_pslverr;

   logic [3:0] rdy;
   logic [3:0][31:0] rd;
   logic [3:0] err;
   logic [3:0][31:0] opaddr;
   logic [3:0] opsel;
   logic [3:0] open_;
   logic [3:0][2:0] oprot;
   logic [3:0] opwr;
   logic [3:0][31:0] opwdata;
   logic [3:0][3:0] opstrb;
   logic [3:0] bsy;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      apb_ratio_delayer #(
         .MODE (P_MODE[g]),
         .R_FX (P_RFX[g])
      ) u_dut (
         .clock       (clock),
         .reset       (reset),
         .cfg_bypass  (cfg_bypass),
         .in_paddr    (in_paddr),
         .in_psel     (in_psel),
         .in_penable  (in_penable),
         .in_pprot    (in_pprot),
         .in_pwrite   (in_pwrite),
         .in_pwdata   (in_pwdata),
         .in_pstrb    (in_pstrb),
         .in_pready   (rdy[g]),
         .in_prdata   (rd[g]),
         .in_pslverr  (err[g]),
         .out_paddr   (opaddr[g]),
         .out_psel    (opsel[g]),
         .out_penable (open_[g]),
         .out_pprot   (oprot[g]),
         .out_pwrite  (opwr[g]),
         .out_pwdata  (opwdata[g]),
         .out_pstrb   (opstrb[g]),
         .out_pready  (out_pready),
         .out_prdata  (out_prdata),
         .out_pslverr (out_pslverr),
         .busy        (bsy[g])
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          dut;
      int          rc;
      logic        wr;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t vecs [9];
   exp_t sb [$];
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      in_psel = 1'b0;
      in_penable = 1'b0;
      out_pready = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int id, input bit do_rst);
      bit done;
      int pcnt;
      exp_t e;
      if (do_rst) apply_reset();
      in_paddr  = 32'h4000_0000 + 32'(id * 4);
      in_pwrite = v.wr;
      in_pwdata = ~v.rdata;
      in_pprot  = 3'b010;
      in_pstrb  = 4'hF;
      in_psel   = 1'b1;
      in_penable = 1'b0;
      @(posedge clock); #1;
      in_penable = 1'b1;
      sb.push_back('{v.cyc, v.rdata, v.err});
      done = 1'b0;
      pcnt = 0;
      for (int n = 1; n <= 200 && !done; n++) begin
         out_pready  = (n == v.rc);
         out_prdata  = (n == v.rc) ? v.rdata : 32'h0BAD_0BAD;
         out_pslverr = (n == v.rc) ? v.err : ~v.err;
         @(negedge clock);
         if (opsel[v.dut]) pcnt++;
         if (n == 1)
            chk($sformatf("v%0d mirror", id),
                {opaddr[v.dut], opwdata[v.dut]}, {in_paddr, in_pwdata});
         if (rdy[v.dut]) begin
            done = 1'b1;
            e = sb.pop_front();
            chk($sformatf("v%0d ready_cycle", id), 64'(n), 64'(e.cyc));
            chk($sformatf("v%0d rdata", id), 64'(rd[v.dut]), 64'(e.rdata));
            chk($sformatf("v%0d slverr", id), 64'(err[v.dut]), 64'(e.err));
         end
         @(posedge clock); #1;
      end
      in_psel = 1'b0;
      in_penable = 1'b0;
      out_pready = 1'b0;
      if (!done) begin
         chk($sformatf("v%0d timeout", id), 64'(0), 64'(1));
         void'(sb.pop_front());
      end
      chk($sformatf("v%0d psel_cycles", id), 64'(pcnt), 64'(v.rc));
      @(negedge clock);
      chk($sformatf("v%0d one_cycle_ready", id),
          {62'd0, rdy[v.dut], bsy[v.dut]}, 64'd0);
   endtask

   initial begin
      vecs[0] = '{0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, 2};
      vecs[1] = '{1, 3, 1'b0, 32'h1234_5678, 1'b0, 31};
      vecs[2] = '{2, 5, 1'b1, 32'hA5A5_A5A5, 1'b1, 8};
      vecs[3] = '{3, 2, 1'b0, 32'h0F0F_0F0F, 1'b0, 19};
      vecs[4] = '{1, 1, 1'b1, 32'h1111_2222, 1'b1, 11};
      vecs[5] = '{2, 1, 1'b0, 32'h3333_4444, 1'b0, 2};
      vecs[6] = '{2, 2, 1'b0, 32'h5555_6666, 1'b0, 4};
      vecs[7] = '{0, 6, 1'b1, 32'h7777_8888, 1'b1, 7};
      vecs[8] = '{3, 1, 1'b0, 32'h9999_AAAA, 1'b0, 18};

      cfg_bypass = 1'b0;
      in_paddr = '0;
      in_pprot = '0;
      in_pwrite = 1'b0;
      in_pwdata = '0;
      in_pstrb = '0;
      out_prdata = '0;
      out_pslverr = 1'b0;
      apply_reset();
      @(negedge clock);
      chk("reset_ready", 64'(rdy), 64'd0);
      chk("reset_busy", 64'(bsy), 64'd0);
      chk("reset_prdata", {rd[1], rd[3]}, 64'd0);
      chk("reset_slverr", 64'(err), 64'd0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i, 1'b1);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      // reset while dut1 sits in DELAY with dcnt=10
      apply_reset();
      in_psel = 1'b1;
      in_penable = 1'b0;
      @(posedge clock); #1;
      in_penable = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         out_pready = (n == 2);
         out_prdata = 32'hCAFE_F00D;
         @(posedge clock); #1;
      end
      chk("mid_delay_busy", {62'd0, bsy[1], opsel[1]}, 64'd2);
      reset = 1'b1;
      in_psel = 1'b0;
      in_penable = 1'b0;
      out_pready = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abandon_state", {30'd0, rd[1], bsy[1], rdy[1]}, 64'd0);
      begin
         int seen = 0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (rdy[1]) seen++;
         end
         chk("abandon_no_ready", 64'(seen), 64'd0);
      end
      @(posedge clock); #1;
      run_vec(vecs[1], 9, 1'b0);

      // bypass: combinational pass-through, never busy
      cfg_bypass = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      for (int i = 0; i < 10; i++) begin
         logic [31:0] val;
         val = 32'h1000_0000 * 32'(i) + 32'h0000_ABCD;
         in_psel = 1'b1;
         in_penable = 1'b0;
         out_pready = 1'b0;
         @(posedge clock); #1;
         in_penable = 1'b1;
         if (i[0]) begin
            out_prdata = 32'h0;
            #1;
            chk($sformatf("byp%0d wait", i), 64'(rdy[1]), 64'd0);
            @(posedge clock); #1;
         end
         out_pready = 1'b1;
         out_prdata = val;
         out_pslverr = i[1];
         #1;
         chk($sformatf("byp%0d pass", i),
             {29'd0, rdy[1], bsy[1], opsel[1], err[1], rd[1]},
             {29'd0, 1'b1, 1'b0, 1'b1, i[1], val});
         @(posedge clock); #1;
         in_psel = 1'b0;
         in_penable = 1'b0;
         out_pready = 1'b0;
         @(negedge clock);
         chk($sformatf("byp%0d busy", i), 64'(bsy), 64'd0);
      end
      cfg_bypass = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/apb_ratio_delayer.md
Name: apb_ratio_delayer

Overview:
- Parametrised successor to the pass-through APB delayer. Sits between the SoC APB crossbar and a slow APB peripheral.
- Stretches every transfer so the upstream master sees the slave's latency scaled by a fixed-point ratio R (emulating a slower-clocked device), or extended by a fixed cycle count.
- Captures the response, holds it for the computed delay, then completes the upstream transfer.
- A runtime bypass gives pure combinational pass-through.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; pstrb width is DATA_W/8.
- MODE, 0, 0 = ratio mode, 1 = fixed-extra mode.
- S, 3, fractional bits of the ratio.
- R_FX, 80, ratio in fixed point (R_FX / 2^S; default 10.0). Must be >= 2^S.
- FIXED_DLY, 16, extra cycles added in fixed-extra mode.
- CNT_W, 32, accumulator and counter width; saturating.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_bypass  in  1  1 = combinational pass-through; sampled only in IDLE.
- in_paddr  in  ADDR_W  upstream address.
- in_psel  in  1  upstream select.
- in_penable  in  1  upstream enable.
- in_pprot  in  3  upstream protection.
- in_pwrite  in  1  upstream write.
- in_pwdata  in  DATA_W  upstream write data.
- in_pstrb  in  DATA_W/8  upstream strobes.
- in_pready  out  1  upstream ready.
- in_prdata  out  DATA_W  upstream read data.
- in_pslverr  out  1  upstream error.
- out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb  out  (as in_*)  downstream request.
- out_pready  in  1  downstream ready.
- out_prdata  in  DATA_W  downstream read data.
- out_pslverr  in  1  downstream error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, DELAY, RESP. Registers: state, acc (CNT_W), k (cycle count, CNT_W), dcnt (CNT_W), rdata, pslverr, byp.
- Reset values: state=IDLE, acc=k=dcnt=0, rdata=0, pslverr=0, byp=0. All outputs follow from these: in_pready=0, in_prdata=0, in_pslverr=0, busy=0.
- Reset has priority in every state. Reset during DELAY or RESP abandons the transfer; in_pready is never asserted for it.
- IDLE:
  - byp <= cfg_bypass every cycle.
  - If byp=1: all out_* = in_*, in_pready=out_pready, in_prdata=out_prdata, in_pslverr=out_pslverr; state does not leave IDLE.
  - If byp=0: out_* = in_*; in_pready=0.
  - When in_psel & in_penable & !byp: this counts as access cycle 1. Set k<=1 and acc<=R_FX.
    - If out_pready is also high, capture the response and compute D directly (see below).
    - Otherwise go to ACCESS.
- ACCESS:
  - out_* = in_*; in_pready=0.
  - Each cycle: k<=k+1, acc<=acc+R_FX, both saturating at 2^CNT_W-1.
  - On out_pready: capture rdata<=out_prdata and pslverr<=out_pslverr. Compute D with k and acc including the current cycle. dcnt<=D. Go to DELAY if D>0, else RESP.
  - If in_psel falls (protocol abort): return to IDLE with no capture.
- Delay D:
  - Ratio mode: D = (acc >> S) - k, saturated at 0.
  - Fixed-extra mode: D = FIXED_DLY.
- DELAY:
  - out_psel=out_penable=out_pprot=0; out_paddr, out_pwrite, out_pwdata, out_pstrb still mirror in_*.
  - dcnt decrements each cycle; moves to RESP in the cycle dcnt==1.
- RESP:
  - Downstream signals as in DELAY.
  - in_pready=1, in_prdata=rdata, in_pslverr=pslverr for exactly one cycle; then IDLE with acc=k=0.
- Outside RESP in non-bypass mode: in_prdata=rdata, in_pslverr=pslverr, in_pready=0.
- Upstream access-phase length = k + D + 1 cycles. With R_FX=2^S, D=0, so there is exactly one cycle of penalty.
- cfg_bypass changes outside IDLE take effect only at the next IDLE.

Test Plan:
- R_FX=8, S=3, slave zero-wait (out_pready=1 on the first access cycle) -> D=0; in_pready asserted on access cycle 2 with in_prdata equal to the captured out_prdata (0xDEADBEEF).
- R_FX=80, slave ready on access cycle 3 -> acc=240, D=30-3=27; in_pready on upstream access cycle 31 for one cycle; out_psel=0 for cycles 4-31.
- R_FX=12 (ratio 1.5), slave ready on access cycle 5 -> acc=60, D=7-5=2; in_pready on cycle 8; slverr=1 captured and presented with in_pready.
- MODE=1, FIXED_DLY=16, slave ready on cycle 2 -> in_pready on cycle 19.
- cfg_bypass=1 in IDLE -> in_pready/in_prdata track out_pready/out_prdata combinationally; busy stays 0 for 10 back-to-back transfers.
- reset pulsed mid-DELAY (dcnt=10) -> next cycle state=IDLE, busy=0, in_prdata=0, in_pready never asserted; the next transfer completes normally.
